// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared widths, FSM state type and a grant-vector helper for the ALU arbiter.
package alu_arbiter_pkg;

    localparam int DATA_WIDTH           = 32;
    localparam int DATA_INDEX_LIMIT     = DATA_WIDTH - 1;
    localparam int ALU_OPRN_WIDTH       = 6;
    localparam int ALU_OPRN_INDEX_LIMIT = ALU_OPRN_WIDTH - 1;

    typedef enum logic {
        ALU_ARB_IDLE = 1'b0,
        ALU_ARB_EXEC = 1'b1
    } arb_state_e;

    // One-hot per-port pulse vector from a port index.
    function automatic logic [1:0] port_vec(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle between the two requesters plus the shared ALU (master) and the arbiter (slave).
//   req/oprn/op1/op2      per-port request and operands, index = port
//   gnt/done/res/zero     per-port grant pulse, done pulse, held result and zero flag
//   alu_op1/op2/oprn      registered operands driven to the ALU
//   alu_out/alu_zero      combinational ALU result
//   busy                  high while an operation is executing
interface alu_arbiter_if import alu_arbiter_pkg::*; #(
    parameter int DATA_WIDTH = alu_arbiter_pkg::DATA_WIDTH,
    parameter int OPRN_WIDTH = ALU_OPRN_WIDTH
) ();
    logic [1:0]                 req;
    logic [1:0][OPRN_WIDTH-1:0] oprn;
    logic [1:0][DATA_WIDTH-1:0] op1;
    logic [1:0][DATA_WIDTH-1:0] op2;
    logic [1:0]                 gnt;
    logic [1:0]                 done;
    logic [1:0][DATA_WIDTH-1:0] res;
    logic [1:0]                 zero;
    logic [DATA_WIDTH-1:0]      alu_op1;
    logic [DATA_WIDTH-1:0]      alu_op2;
    logic [OPRN_WIDTH-1:0]      alu_oprn;
    logic [DATA_WIDTH-1:0]      alu_out;
    logic                       alu_zero;
    logic                       busy;

    modport master (
        output req, oprn, op1, op2, alu_out, alu_zero,
        input  gnt, done, res, zero, alu_op1, alu_op2, alu_oprn, busy
    );

    modport slave (
        input  req, oprn, op1, op2, alu_out, alu_zero,
        output gnt, done, res, zero, alu_op1, alu_op2, alu_oprn, busy
    );
endinterface

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way pick.
//   req0_i/req1_i  requests
//   last_i         port granted most recently
//   fixed_prio_i   1 = port 0 wins ties, 0 = the port not granted last wins ties
//   win_o          chosen port index (meaningful when any_o)
//   any_o          at least one request present
module rr_arbiter_2 import alu_arbiter_pkg::*; (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    input  logic fixed_prio_i,
    output logic win_o,
    output logic any_o
);
    assign any_o = req0_i | req1_i;
    assign win_o = (req0_i && req1_i) ? (!fixed_prio_i && !last_i) : req1_i;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with grant/done handshakes.
//   clk_i          system clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   bus_io         requests, operands, per-port results and the ALU connection (slave side)
// An accepted request spends one EXEC cycle with operands registered on the ALU inputs;
// the result is captured into the winner's result register on the following edge.
module alu_arbiter import alu_arbiter_pkg::*; #(
    parameter int DATA_WIDTH = alu_arbiter_pkg::DATA_WIDTH,
    parameter int OPRN_WIDTH = ALU_OPRN_WIDTH,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    alu_arbiter_if.slave bus_io
);
    arb_state_e                 state_q, state_d;
    logic                       last_q, own_q;
    logic                       win, any, grant, exec;
    logic [1:0]                 gnt_q, done_q, zero_q;
    logic [1:0][DATA_WIDTH-1:0] res_q;
    logic [DATA_WIDTH-1:0]      op1_q, op2_q;
    logic [OPRN_WIDTH-1:0]      oprn_q;

    rr_arbiter_2 u_pick (
        .req0_i       (bus_io.req[0]),
        .req1_i       (bus_io.req[1]),
        .last_i       (last_q),
        .fixed_prio_i (FIXED_PRIO),
        .win_o        (win),
        .any_o        (any)
    );

    assign exec  = state_q == ALU_ARB_EXEC;
    assign grant = !exec && any;

    always_comb begin
        state_d = state_q;
        if (exec)
            state_d = ALU_ARB_IDLE;
        else if (any)
            state_d = ALU_ARB_EXEC;
    end

    // last_q resets to 1 so port 0 takes the first round-robin tie.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ALU_ARB_IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            zero_q  <= '0;
            res_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            oprn_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= grant ? port_vec(win) : 2'b00;
            done_q  <= exec ? port_vec(own_q) : 2'b00;
            if (grant) begin
                last_q <= win;
                own_q  <= win;
                oprn_q <= bus_io.oprn[win];
                op1_q  <= bus_io.op1[win];
                op2_q  <= bus_io.op2[win];
            end
            if (exec) begin
                res_q[own_q]  <= bus_io.alu_out;
                zero_q[own_q] <= bus_io.alu_zero;
            end
        end
    end

    assign bus_io.gnt      = gnt_q;
    assign bus_io.done     = done_q;
    assign bus_io.res      = res_q;
    assign bus_io.zero     = zero_q;
    assign bus_io.alu_op1  = op1_q;
    assign bus_io.alu_op2  = op2_q;
    assign bus_io.alu_oprn = oprn_q;
    assign bus_io.busy     = exec;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 (control unit) and port 1 (address/branch-calc unit).
- Arbitrates, latches operands and drives the ALU. Captures OUT and ZERO one cycle later and returns them to the winning requester with a one-cycle DONE pulse.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- DATA_WIDTH, 32, operand/result width (matches `DATA_WIDTH).
- OPRN_WIDTH, 6, ALU operation code width (matches `ALU_OPRN_WIDTH).
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ0  in  1  port 0 request.
- OPRN0  in  OPRN_WIDTH  port 0 operation code.
- OP1_0  in  DATA_WIDTH  port 0 operand 1.
- OP2_0  in  DATA_WIDTH  port 0 operand 2.
- GNT0  out  1  port 0 request accepted (1-cycle pulse).
- DONE0  out  1  port 0 result valid (1-cycle pulse).
- RES0  out  DATA_WIDTH  port 0 result, held until next port-0 capture.
- ZERO0  out  1  port 0 zero flag, held like RES0.
- REQ1, OPRN1, OP1_1, OP2_1, GNT1, DONE1, RES1, ZERO1: same as port 0, for port 1.
- ALU_OP1  out  DATA_WIDTH  to ALU OP1.
- ALU_OP2  out  DATA_WIDTH  to ALU OP2.
- ALU_OPRN  out  OPRN_WIDTH  to ALU OPRN.
- ALU_OUT  in  DATA_WIDTH  from ALU OUT.
- ALU_ZERO  in  1  from ALU ZERO.
- BUSY  out  1  high while state is EXEC.

Behaviour:
- RST low, at any time including mid-operation:
  - state = IDLE; last-grant pointer = 1, so port 0 wins the first tie.
  - All GNT/DONE/BUSY = 0; RES0/RES1 = 0; ZERO0/ZERO1 = 0.
  - ALU_OP1/ALU_OP2 = 0; ALU_OPRN = 0.
  - An in-flight operation is discarded; no DONE is issued for it.
- State IDLE:
  - REQ0/REQ1 are sampled on each rising edge.
  - No request: stay in IDLE; ALU_* keep their last values.
  - At least one request: winner = the only requester. On a tie: port 0 if FIXED_PRIO = 1, else the port not equal to the last-grant pointer.
  - On that edge: winner's OPRN/OP1/OP2 are latched into ALU_OPRN/ALU_OP1/ALU_OP2; GNTx = 1 next cycle; pointer = winner; state -> EXEC.
- State EXEC (exactly one cycle, BUSY = 1):
  - The ALU evaluates the registered operands combinationally.
  - On the next edge: ALU_OUT -> RESx and ALU_ZERO -> ZEROx for the winner only; DONEx = 1 for one cycle; state -> IDLE.
  - The other port's RES/ZERO are unchanged.
- Request sampling:
  - REQ is ignored in EXEC. Operands are captured only at the grant edge, so a requester may change them after GNT.
  - A requester must drop REQ in the cycle it sees GNT, or it is re-arbitrated at the next IDLE edge (legal back-to-back use).
- Latency and throughput:
  - REQ sampled at edge E0 -> GNT high during E0..E1 -> DONE/RES valid during E1..E2.
  - Maximum throughput is one operation per 2 cycles.
  - With both REQs held continuously and FIXED_PRIO = 0, grants alternate 0,1,0,1.
- OPRN values are passed to the ALU unvalidated. An unsupported code yields whatever the ALU produces, and DONE is still issued.
- GNT0/GNT1 are never high together; likewise DONE0/DONE1. DONE never coincides with GNT of the same operation.

Decomposition:
- Shared definitions file:
  - Reuse `DATA_WIDTH, `DATA_INDEX_LIMIT, `ALU_OPRN_WIDTH, `ALU_OPRN_INDEX_LIMIT.
  - Add `ALU_ARB_IDLE = 1'b0 and `ALU_ARB_EXEC = 1'b1.
- Sub-module rr_arbiter_2: combinational 2-way pick.
  - Inputs: REQ0, REQ1, LAST, FIXED_PRIO.
  - Outputs: WIN (port index), ANY.
- The top level holds the state register, operand/result registers and pulses.
- The bench instantiates the real ALU behind the arbiter and checks results against a golden model.

Test Plan:
- Single request: REQ0=1, OPRN0=0x01, OP1_0=15, OP2_0=3 at E0 -> GNT0 high E0..E1, ALU_OPRN=0x01, DONE0 high E1..E2, RES0=18, ZERO0=0; port 1 outputs unchanged.
- Tie, round-robin: after reset, REQ0 (0x02, 15, 5) and REQ1 (0x03, 2, 5) held continuously -> GNT order 0,1,0,1; RES0=10, RES1=10; no simultaneous GNTs.
- Fixed priority: FIXED_PRIO=1, both REQs held for 8 cycles -> only GNT0/DONE0 pulse; GNT1 never asserted.
- Zero flag: REQ1 with OPRN=0x02, 7, 7 -> RES1=0, ZERO1=1; then REQ1 with 0x06, 15, 5 -> RES1=5, ZERO1=0.
- Reset in EXEC: assert REQ1 (0x05, 7, 3), pull RST low during BUSY=1 -> DONE1 never pulses; RES1=0; ALU_* = 0; state IDLE; next REQ0/REQ1 tie grants port 0.
- Hold and late REQ: REQ1 asserted while BUSY=1 for port 0 -> ignored until IDLE, granted at the first IDLE edge; RES0 stays stable throughout.
